// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the RAM port of the memory arbiter.
// Latency: none; wires only.
// Backpressure: requesters hold their cmd until they see their ack pulse.
//
// Ports are grouped per side:
//   c_*   : CPU requester (cmd/addr/wdata in, ack/rdata out)
//   l_*   : loader/debug requester (same shape; l_lock when MEM_ARB_LOCK_EN)
//   ram_* : single-port synchronous RAM (addr/write/din out, dout in)
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [1:0]    c_mem_cmd;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_ack;
    logic [DW-1:0] c_rdata;

    logic [1:0]    l_mem_cmd;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_ack;
    logic [DW-1:0] l_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic          l_lock;
`endif

    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  c_mem_cmd, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  l_mem_cmd, l_addr, l_wdata,
        output l_ack, l_rdata,
`ifdef MEM_ARB_LOCK_EN
        input  l_lock,
`endif
        output ram_addr, ram_write, ram_din,
        input  ram_dout
    );

    modport master (
        output c_mem_cmd, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output l_mem_cmd, l_addr, l_wdata,
        input  l_ack, l_rdata,
`ifdef MEM_ARB_LOCK_EN
        output l_lock,
`endif
        input  ram_addr, ram_write, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM between CPU (C) and loader (L).
// Latency: write ack 2 cycles, read ack 3 cycles after the idle cycle that samples the request.
// Backpressure: a requester holds cmd until its one-cycle ack; inputs are sampled only in idle.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave (C port, L port, RAM port)
// Optional build macro MEM_ARB_LOCK_EN: adds bus.l_lock; while high, C is never
// granted and the round-robin pointer is frozen.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    logic [1:0]    state;
    logic          ptr_l;      // 0: C has priority, 1: L has priority
    logic          win_l;      // latched winner: 0 = C, 1 = L
    logic [1:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] l_rdata_q;

    logic c_req;
    logic l_req;
    logic c_elig;
    logic locked;
    logic grant_c;
    logic grant_l;

    // cmd 11 is not a request
    assign c_req = (bus.c_mem_cmd == MREAD) || (bus.c_mem_cmd == MWRITE);
    assign l_req = (bus.l_mem_cmd == MREAD) || (bus.l_mem_cmd == MWRITE);

`ifdef MEM_ARB_LOCK_EN
    assign locked = bus.l_lock;
`else
    assign locked = 1'b0;
`endif

    assign c_elig  = c_req && !locked;
    assign grant_l = l_req && (!c_elig || ptr_l);
    assign grant_c = c_elig && (!l_req || !ptr_l);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr_l     <= 1'b0;
            win_l     <= 1'b0;
            cmd_q     <= 2'b00;
            addr_q    <= '0;
            din_q     <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_c || grant_l) begin
                        win_l  <= grant_l;
                        cmd_q  <= grant_l ? bus.l_mem_cmd : bus.c_mem_cmd;
                        addr_q <= grant_l ? bus.l_addr    : bus.c_addr;
                        din_q  <= grant_l ? bus.l_wdata   : bus.c_wdata;
                        // Pointer goes to the loser; frozen while locked so
                        // round-robin resumes where it left off.
                        if (!locked) begin
                            ptr_l <= grant_c;
                        end
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    state <= (cmd_q == MREAD) ? S_READ : S_ACK;
                end
                S_READ: begin
                    if (win_l) begin
                        l_rdata_q <= bus.ram_dout;
                    end else begin
                        c_rdata_q <= bus.ram_dout;
                    end
                    state <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so an aborted access neither writes nor acknowledges.
    assign bus.ram_write = (state == S_ACCESS) && (cmd_q == MWRITE) && !reset;
    assign bus.c_ack     = (state == S_ACK) && !win_l && !reset;
    assign bus.l_ack     = (state == S_ACK) &&  win_l && !reset;

    assign bus.ram_addr  = addr_q;
    assign bus.ram_din   = din_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(8), .DW(16)) bus ();

    mem_arbiter #(.AW(8), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: write and read both sampled at the rising edge
    logic [15:0] mem [256] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // Edge monitors
    int wr_cnt = 0;
    int c_ack_cnt = 0;
    int l_ack_cnt = 0;
    int overlap_cnt = 0;
    always @(posedge clk) begin
        if (bus.ram_write === 1'b1) wr_cnt++;
        if (bus.c_ack === 1'b1) c_ack_cnt++;
        if (bus.l_ack === 1'b1) l_ack_cnt++;
        if (bus.c_ack === 1'b1 && bus.l_ack === 1'b1) overlap_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until an ack is visible, bounded to 12 cycles
    task automatic wait_ack(output logic is_c, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!(bus.c_ack === 1'b1 || bus.l_ack === 1'b1) && n < 12);
        is_c = (bus.c_ack === 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c_ack"},   {31'd0, bus.c_ack},     32'd0);
        check({tag, "_l_ack"},   {31'd0, bus.l_ack},     32'd0);
        check({tag, "_ram_wr"},  {31'd0, bus.ram_write}, 32'd0);
        check({tag, "_ram_addr"},{24'd0, bus.ram_addr},  32'd0);
        check({tag, "_ram_din"}, {16'd0, bus.ram_din},   32'd0);
        check({tag, "_c_rdata"}, {16'd0, bus.c_rdata},   32'd0);
        check({tag, "_l_rdata"}, {16'd0, bus.l_rdata},   32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    logic is_c;
    int   n;
    int   wr0, ca0, la0;

    initial begin
        reset = 1'b1;
        bus.c_mem_cmd = 2'b00; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_mem_cmd = 2'b00; bus.l_addr = '0; bus.l_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        bus.l_lock = 1'b0;
`endif
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // ---- C write 05 = ABCD
        wr0 = wr_cnt;
        bus.c_mem_cmd = 2'b10; bus.c_addr = 8'h05; bus.c_wdata = 16'hABCD;
        tick(1);
        check("wr_access_ram_write", {31'd0, bus.ram_write}, 32'd1);
        check("wr_access_ram_addr",  {24'd0, bus.ram_addr},  32'h05);
        check("wr_access_ram_din",   {16'd0, bus.ram_din},   32'hABCD);
        check("wr_access_c_ack",     {31'd0, bus.c_ack},     32'd0);
        tick(1);
        check("wr_ack_c_ack",        {31'd0, bus.c_ack},     32'd1);
        check("wr_ack_l_ack",        {31'd0, bus.l_ack},     32'd0);
        check("wr_ack_ram_write",    {31'd0, bus.ram_write}, 32'd0);
        bus.c_mem_cmd = 2'b00;
        tick(1);
        check("wr_after_c_ack",      {31'd0, bus.c_ack},     32'd0);
        check("wr_pulse_count",      wr_cnt - wr0,           32'd1);
        check("wr_mem05",            {16'd0, mem[8'h05]},    32'hABCD);

        // ---- C read 05
        bus.c_mem_cmd = 2'b01; bus.c_addr = 8'h05;
        tick(1);
        check("rd_access_ram_write", {31'd0, bus.ram_write}, 32'd0);
        tick(1);
        check("rd_read_c_ack",       {31'd0, bus.c_ack},     32'd0);
        tick(1);
        check("rd_ack_c_ack",        {31'd0, bus.c_ack},     32'd1);
        check("rd_ack_c_rdata",      {16'd0, bus.c_rdata},   32'hABCD);
        check("rd_ack_l_rdata",      {16'd0, bus.l_rdata},   32'h0000);
        bus.c_mem_cmd = 2'b00;
        tick(2);
        check("rd_held_c_rdata",     {16'd0, bus.c_rdata},   32'hABCD);
        check("rd_held_c_ack",       {31'd0, bus.c_ack},     32'd0);

        // Seed address 01 for the contention test
        bus.c_mem_cmd = 2'b10; bus.c_addr = 8'h01; bus.c_wdata = 16'h5A5A;
        wait_ack(is_c, n);
        check("seed_ack_c", {31'd0, is_c}, 32'd1);
        bus.c_mem_cmd = 2'b00;
        tick(1);

        // ---- Contention right after reset: C read 01, L write 02
        do_reset();
        bus.c_mem_cmd = 2'b01; bus.c_addr = 8'h01;
        bus.l_mem_cmd = 2'b10; bus.l_addr = 8'h02; bus.l_wdata = 16'h1234;
        wait_ack(is_c, n);
        check("rr1_is_c",    {31'd0, is_c},        32'd1);
        check("rr1_latency", n,                    32'd3);
        check("rr1_c_rdata", {16'd0, bus.c_rdata}, 32'h5A5A);
        wait_ack(is_c, n);
        check("rr2_is_c",    {31'd0, is_c},        32'd0);
        check("rr2_latency", n,                    32'd3);
        wait_ack(is_c, n);
        check("rr3_is_c",    {31'd0, is_c},        32'd1);
        check("rr3_latency", n,                    32'd4);
        wait_ack(is_c, n);
        check("rr4_is_c",    {31'd0, is_c},        32'd0);
        check("rr4_latency", n,                    32'd3);
        bus.c_mem_cmd = 2'b00; bus.l_mem_cmd = 2'b00;
        tick(1);
        check("rr_mem02",    {16'd0, mem[8'h02]},  32'h1234);
        check("rr_l_rdata",  {16'd0, bus.l_rdata}, 32'h0000);

        // ---- L read 02: only l_rdata changes
        bus.l_mem_cmd = 2'b01; bus.l_addr = 8'h02;
        wait_ack(is_c, n);
        check("lrd_is_c",    {31'd0, is_c},        32'd0);
        check("lrd_latency", n,                    32'd3);
        check("lrd_l_rdata", {16'd0, bus.l_rdata}, 32'h1234);
        check("lrd_c_rdata", {16'd0, bus.c_rdata}, 32'h5A5A);
        bus.l_mem_cmd = 2'b00;
        tick(1);

        // ---- Reset during sAccess of an L write to 10
        wr0 = wr_cnt; la0 = l_ack_cnt;
        bus.l_mem_cmd = 2'b10; bus.l_addr = 8'h10; bus.l_wdata = 16'hBEEF;
        tick(1);
        reset = 1'b1;
        #1;
        check("abort_ram_write", {31'd0, bus.ram_write}, 32'd0);
        bus.l_mem_cmd = 2'b00;
        tick(1);
        check_all_zero("abort");
        reset = 1'b0;
        tick(4);
        check("abort_wr_count", wr_cnt - wr0,         32'd0);
        check("abort_l_acks",   l_ack_cnt - la0,      32'd0);
        check("abort_mem10",    {16'd0, mem[8'h10]},  32'h0000);

        // ---- cmd 11 on both ports is ignored
        wr0 = wr_cnt; ca0 = c_ack_cnt; la0 = l_ack_cnt;
        bus.c_mem_cmd = 2'b11; bus.l_mem_cmd = 2'b11;
        tick(5);
        check("cmd11_wr_count", wr_cnt - wr0,         32'd0);
        check("cmd11_c_acks",   c_ack_cnt - ca0,      32'd0);
        check("cmd11_l_acks",   l_ack_cnt - la0,      32'd0);
        check("cmd11_ram_addr", {24'd0, bus.ram_addr}, 32'h00);
        bus.c_mem_cmd = 2'b00; bus.l_mem_cmd = 2'b00;
        tick(1);
        // Idle must still be live after the ignored commands
        bus.c_mem_cmd = 2'b10; bus.c_addr = 8'h30; bus.c_wdata = 16'h0F0F;
        wait_ack(is_c, n);
        check("post11_is_c",    {31'd0, is_c}, 32'd1);
        check("post11_latency", n,             32'd2);
        bus.c_mem_cmd = 2'b00;
        tick(1);

`ifdef MEM_ARB_LOCK_EN
        // ---- Lock: only L is served; C gets the next grant after unlock
        do_reset();
        bus.l_lock = 1'b1;
        ca0 = c_ack_cnt; la0 = l_ack_cnt;
        bus.c_mem_cmd = 2'b10; bus.c_addr = 8'h20; bus.c_wdata = 16'h1111;
        bus.l_mem_cmd = 2'b10; bus.l_addr = 8'h21; bus.l_wdata = 16'h2222;
        tick(12);
        check("lock_c_acks", c_ack_cnt - ca0, 32'd0);
        check("lock_l_acks", l_ack_cnt - la0, 32'd4);
        bus.l_lock = 1'b0;
        wait_ack(is_c, n);
        check("unlock_is_c",    {31'd0, is_c}, 32'd1);
        check("unlock_latency", n,             32'd2);
        bus.c_mem_cmd = 2'b00; bus.l_mem_cmd = 2'b00;
        tick(4);
`endif

        check("ack_overlap", overlap_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
